// File: rtl/keypad_loader_pkg.sv
// Shared definitions for the microwave keypad loader: FSM encoding and sizing constants.
package keypad_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned NUM_KEYS   = 10;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned MAX_TENS   = 5;
  localparam int unsigned LOAD_BEATS = 6;
  localparam int unsigned BEAT_W     = $clog2(LOAD_BEATS);

  typedef logic [3:0] bcd_t;

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/keypad_loader_if.sv
// Keypad/timer signal bundle between the loader and its environment.
interface keypad_loader_if;
  logic [9:0] keys;
  logic       start_key;
  logic       cancel_key;
  logic       timer_done;
  logic [3:0] digit;
  logic       loadn;
  logic       count_enable;
  logic [3:0] entry_min;
  logic [3:0] entry_tens;
  logic [3:0] entry_secs;
  logic       error;

  modport master (
    output keys, start_key, cancel_key, timer_done,
    input  digit, loadn, count_enable, entry_min, entry_tens, entry_secs, error
  );

  modport slave (
    input  keys, start_key, cancel_key, timer_done,
    output digit, loadn, count_enable, entry_min, entry_tens, entry_secs, error
  );
endinterface

// File: rtl/keypad_loader_key_encoder.sv
// One-hot keypad to BCD encoder; a press is valid only when exactly one key
// rises out of an all-released keypad.
module key_encoder
  import keypad_loader_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic                key_valid_o,
  output bcd_t                key_bcd_o
);

  logic [NUM_KEYS-1:0] keys_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      keys_prev_q <= '0;
    end else begin
      keys_prev_q <= keys_i;
    end
  end

  always_comb begin
    key_bcd_o = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keys_i[i]) begin
        key_bcd_o = 4'(i);
      end
    end
  end

  assign key_valid_o = is_onehot(keys_i) && (keys_prev_q == '0);

endmodule

// File: rtl/keypad_loader.sv
// Keypad entry buffer and timer loader: collects three BCD digits, then
// strobes them into the countdown timer and enables counting.
module keypad_loader
  import keypad_loader_pkg::*;
(
  input  logic            CLK,
  input  logic            clear,
  keypad_loader_if.slave  kp
);

  state_e                        state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [NUM_DIGITS-1:0][3:0]    entry_q, entry_d;
  logic                          error_q, error_d;
  logic                          start_prev_q, cancel_prev_q;

  logic       key_valid;
  bcd_t       key_bcd;
  logic       start_edge, cancel_edge;
  bcd_t       digit_c;
  logic       loadn_c, count_en_c;

  key_encoder u_key_encoder (
    .clk_i       (CLK),
    .rst_i       (clear),
    .keys_i      (kp.keys),
    .key_valid_o (key_valid),
    .key_bcd_o   (key_bcd)
  );

  assign start_edge  = kp.start_key  & ~start_prev_q;
  assign cancel_edge = kp.cancel_key & ~cancel_prev_q;

  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      entry_q       <= '0;
      error_q       <= 1'b0;
      start_prev_q  <= 1'b0;
      cancel_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      entry_q       <= entry_d;
      error_q       <= error_d;
      start_prev_q  <= kp.start_key;
      cancel_prev_q <= kp.cancel_key;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    entry_d    = entry_q;
    error_d    = 1'b0;
    digit_c    = '0;
    loadn_c    = 1'b1;
    count_en_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        // Cancel outranks start when both rise together.
        if (cancel_edge) begin
          entry_d = '0;
        end else if (start_edge) begin
          if ((entry_q[1] > 4'(MAX_TENS)) || (entry_q == '0)) begin
            error_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (key_valid) begin
          entry_d = {entry_q[NUM_DIGITS-2:0], key_bcd};
        end
      end

      ST_LOAD: begin
        // Each digit is held for a beat pair; the strobe sits on the even beat.
        digit_c = entry_q[2'(NUM_DIGITS-1) - beat_q[2:1]];
        loadn_c = beat_q[0];
        if (cancel_edge) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          entry_d = '0;
        end else if (beat_q == BEAT_W'(LOAD_BEATS-1)) begin
          state_d = ST_RUN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      ST_RUN: begin
        count_en_c = 1'b1;
        if (cancel_edge || kp.timer_done) begin
          state_d = ST_IDLE;
          entry_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  assign kp.digit        = digit_c;
  assign kp.loadn        = loadn_c;
  assign kp.count_enable = count_en_c;
  assign kp.entry_min    = entry_q[2];
  assign kp.entry_tens   = entry_q[1];
  assign kp.entry_secs   = entry_q[0];
  assign kp.error        = error_q;

endmodule
